demux1_4_dispatch: RTL and testbench

Registered 1-to-4 dispatch stage that feeds four downstream consumers from one valid/ready input stream.
- Each accepted input word is routed to the channel named by its 2-bit select and held in that channel's one-entry output register until the consumer takes it.
- It is the sequential, flow-controlled counterpart of the combinational 1:4 demux: same select encoding (00→ch0 … 11→ch3), but with back-pressure and per-channel buffering.

---
 rtl/demux_dispatch_pkg.sv | 28 ++
 rtl/demux1_4_dispatch_if.sv | 59 +++++
 rtl/demux_chan_buf.sv | 93 +++++++++
 rtl/demux1_4_dispatch.sv | 90 +++++++++
 tb/tb_demux1_4_dispatch.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// demux_dispatch_pkg
//
// Purpose: shared constants and types for the 1-to-4 registered dispatch
//          stage (demux1_4_dispatch) and its per-channel buffer.
//
// Contents:
//   NUM_CH        number of output channels (4)
//   SEL_W         width of a channel index (2)
//   CH0..CH3      channel index constants
//   chan_state_t  per-channel buffer state {EMPTY, FULL}
// ---------------------------------------------------------------------------
package demux_dispatch_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] CH0 = 2'b00;
    localparam logic [SEL_W-1:0] CH1 = 2'b01;
    localparam logic [SEL_W-1:0] CH2 = 2'b10;
    localparam logic [SEL_W-1:0] CH3 = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

endpackage

// File: rtl/demux1_4_dispatch_if.sv
// ---------------------------------------------------------------------------
// demux1_4_dispatch_if
//
// Purpose: bundles the input valid/ready stream and the four output channels
//          of the dispatch stage.
//
// Signals:
//   in_valid   input word present
//   in_ready   stage can take the input word this cycle
//   in_sel     destination channel (00=ch0 .. 11=ch3)
//   in_data    input word
//   out_valid  bit i = channel i holds a word
//   out_ready  bit i = consumer i takes its word this cycle
//   out_data   channel i at [i*DATA_W +: DATA_W]
//   dlv_cnt    channel i delivered count at [i*CNT_W +: CNT_W]
//
// Modports:
//   slave   the dispatch stage itself
//   master  the producer/consumer side driving it
// ---------------------------------------------------------------------------
interface demux1_4_dispatch_if
    import demux_dispatch_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);

    logic                       in_valid;
    logic                       in_ready;
    logic [SEL_W-1:0]           in_sel;
    logic [DATA_W-1:0]          in_data;
    logic [NUM_CH-1:0]          out_valid;
    logic [NUM_CH-1:0]          out_ready;
    logic [NUM_CH*DATA_W-1:0]   out_data;
    logic [NUM_CH*CNT_W-1:0]    dlv_cnt;

    modport slave (
        input  in_valid,
        input  in_sel,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output dlv_cnt
    );

    modport master (
        output in_valid,
        output in_sel,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  dlv_cnt
    );

endinterface

// File: rtl/demux_chan_buf.sv
// ---------------------------------------------------------------------------
// demux_chan_buf
//
// Purpose: one-entry output register slice for a single dispatch channel.
//          Holds a word from load until the consumer takes it, and counts
//          the words it has delivered (wrapping modulo 2^CNT_W).
//
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   load_i   accept a new word into this channel this cycle
//   data_i   word to load
//   ready_i  consumer takes the held word this cycle
//   valid_o  register holds a word
//   data_o   held word (keeps its last value after delivery)
//   cnt_o    delivered-word counter
// ---------------------------------------------------------------------------
module demux_chan_buf
    import demux_dispatch_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  cnt_o
);

    chan_state_t       state_q, state_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              deliver;

    // A delivery is any cycle where the held word meets a ready consumer.
    assign deliver = (state_q == FULL) && ready_i;

    // State, data and counter registers; reset discards the held word and
    // clears the delivery count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. The top only raises load_i when this channel can
    // take a word (empty, or being drained this same cycle), so a load while
    // FULL is always a reload alongside a delivery.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;

        if (deliver) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            EMPTY: begin
                if (load_i) begin
                    state_d = FULL;
                    data_d  = data_i;
                end
            end
            FULL: begin
                if (load_i) begin
                    state_d = FULL;
                    data_d  = data_i;
                end else if (ready_i) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    assign valid_o = (state_q == FULL);
    assign data_o  = data_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/demux1_4_dispatch.sv
// ---------------------------------------------------------------------------
// demux1_4_dispatch
//
// Purpose: registered 1-to-4 dispatch stage. Each accepted input word is
//          routed to one of four single-entry channel buffers and held there
//          until that channel's consumer takes it. A stalled channel only
//          blocks input words addressed to it.
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    demux1_4_dispatch_if.slave (input stream + four output channels)
//
// Configuration:
//   DEMUX_DISPATCH_RR_EN  when defined, in_sel is ignored and words are
//                         dealt to channels 0,1,2,3,0,... by an internal
//                         round-robin pointer that advances on each accept.
// ---------------------------------------------------------------------------
module demux1_4_dispatch
    import demux_dispatch_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux1_4_dispatch_if.slave    bus
);

    logic [SEL_W-1:0]         dest;
    logic                     accept;
    logic [NUM_CH-1:0]        chValid;
    logic [NUM_CH*DATA_W-1:0] chData;
    logic [NUM_CH*CNT_W-1:0]  chCnt;

`ifdef DEMUX_DISPATCH_RR_EN
    logic [SEL_W-1:0] rrPtr_q, rrPtr_d;
    logic             unusedSel;

    // The select input carries no meaning in round-robin mode.
    assign unusedSel = ^bus.in_sel;

    // Round-robin pointer: steps to the next channel only when a word is
    // actually taken, so a stalled target simply holds the pointer.
    always_comb begin
        rrPtr_d = rrPtr_q;
        if (accept) begin
            rrPtr_d = rrPtr_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr_q <= CH0;
        end else begin
            rrPtr_q <= rrPtr_d;
        end
    end

    assign dest = rrPtr_q;
`else
    assign dest = bus.in_sel;
`endif

    // in_ready looks only at the destination channel, and is forced low
    // while reset is held so nothing can be taken during reset.
    assign bus.in_ready = rst_n && (!chValid[dest] || bus.out_ready[dest]);
    assign accept       = bus.in_valid && bus.in_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        demux_chan_buf #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_buf (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (accept && (dest == SEL_W'(i))),
            .data_i  (bus.in_data),
            .ready_i (bus.out_ready[i]),
            .valid_o (chValid[i]),
            .data_o  (chData[i*DATA_W +: DATA_W]),
            .cnt_o   (chCnt[i*CNT_W +: CNT_W])
        );
    end

    assign bus.out_valid = chValid;
    assign bus.out_data  = chData;
    assign bus.dlv_cnt   = chCnt;

endmodule

// File: tb/tb_demux1_4_dispatch.sv
// ---------------------------------------------------------------------------
// tb_demux1_4_dispatch
//
// Purpose: self-checking bench for demux1_4_dispatch. Stimulus pushes each
//          accepted word onto the queue of the channel it should land on; a
//          monitor pops and compares on every output delivery. Directed
//          checks cover reset, latency, back-pressure, channel independence
//          and counter wrap. Build with DEMUX_DISPATCH_RR_EN to exercise the
//          round-robin mode instead of select-based routing.
// ---------------------------------------------------------------------------
module tb_demux1_4_dispatch;
    import demux_dispatch_pkg::*;

    logic clk;
    logic rst_n;
    int   testCount;
    int   failCount;

    logic [7:0] expQ [4][$];

    demux1_4_dispatch_if #(.DATA_W(8), .CNT_W(8)) bus ();

    demux1_4_dispatch #(.DATA_W(8), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges beyond every bounded wait.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] getCnt(input int ch);
        return bus.dlv_cnt[ch*8 +: 8];
    endfunction

    function automatic logic [7:0] getData(input int ch);
        return bus.out_data[ch*8 +: 8];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: sampled mid-cycle, a valid&ready channel will be
    // delivered at the coming edge, so its word must match the oldest
    // expectation for that channel.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.out_valid[i] && bus.out_ready[i]) begin
                    testCount++;
                    if (expQ[i].size() == 0) begin
                        failCount++;
                        $display("[TB] FAIL deliverCh%0d unexpected word actual=%0h expected=none", i, getData(i));
                    end else begin
                        logic [7:0] e;
                        e = expQ[i].pop_front();
                        if (getData(i) !== e) begin
                            failCount++;
                            $display("[TB] FAIL deliverCh%0d actual=%0h expected=%0h", i, getData(i), e);
                        end
                    end
                end
            end
        end
    end

    // Present one word, wait (bounded) for in_ready, record the expectation
    // on the channel it should reach and return one step after the accept.
    task automatic applyStimulus(input logic [1:0] sel, input logic [7:0] data, input int expCh);
        int waited;
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = data;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL sendTimeout actual=stalled expected=accept data=%0h", data);
        end else begin
            expQ[expCh].push_back(data);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic applyReset(input int cycles);
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) expQ[i].delete();
        repeat (cycles) @(posedge clk);
        #1;
        checkOutput("rstValid", 64'(bus.out_valid), 64'h0);
        checkOutput("rstCnt", 64'(bus.dlv_cnt), 64'h0);
        checkOutput("rstData", 64'(bus.out_data), 64'h0);
        checkOutput("rstInReady", 64'(bus.in_ready), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        testCount     = 0;
        failCount     = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'b00;
        bus.in_data   = 8'h00;
        bus.out_ready = 4'b0000;

        // Reset then idle.
        applyReset(3);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idleValid", 64'(bus.out_valid), 64'h0);
        checkOutput("idleCnt", 64'(bus.dlv_cnt), 64'h0);

`ifdef DEMUX_DISPATCH_RR_EN
        // Round robin: fixed in_sel=11, words dealt to 0,1,2,3,0,1.
        bus.out_ready = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(CH3, 8'hC0 + 8'(k), k % 4);
            checkOutput($sformatf("rrValid%0d", k), 64'(bus.out_valid), 64'(4'b0001 << (k % 4)));
            checkOutput($sformatf("rrData%0d", k), 64'(getData(k % 4)), 64'(8'hC0 + 8'(k)));
        end
        @(posedge clk);
        #1;
        checkOutput("rrCnt", 64'(bus.dlv_cnt), 64'h01_01_02_02);

        // Next word goes to ch2; stall it and reset mid-stream.
        bus.out_ready = 4'b0000;
        applyStimulus(CH0, 8'hD6, 2);
        checkOutput("rrStallValid", 64'(bus.out_valid), 64'h4);
        applyReset(2);
        checkOutput("rrPostRstValid", 64'(bus.out_valid), 64'h0);
        bus.out_ready = 4'b1111;
        applyStimulus(CH3, 8'hE0, 0);
        checkOutput("rrRestartValid", 64'(bus.out_valid), 64'h1);
        checkOutput("rrRestartData", 64'(getData(0)), 64'hE0);
        applyStimulus(CH3, 8'hE1, 1);
        checkOutput("rrRestart2Valid", 64'(bus.out_valid), 64'h2);
`else
        // Address sweep with all consumers ready.
        bus.out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'(k), 8'hA0 + 8'(k), k);
            checkOutput($sformatf("sweepValid%0d", k), 64'(bus.out_valid), 64'(4'b0001 << k));
            checkOutput($sformatf("sweepData%0d", k), 64'(getData(k)), 64'(8'hA0 + 8'(k)));
        end
        @(posedge clk);
        #1;
        checkOutput("sweepDrained", 64'(bus.out_valid), 64'h0);
        checkOutput("sweepCnt", 64'(bus.dlv_cnt), 64'h01_01_01_01);

        // Back-pressure on ch2.
        bus.out_ready = 4'b1011;
        applyStimulus(CH2, 8'h55, 2);
        bus.in_valid = 1'b1;
        bus.in_sel   = CH2;
        bus.in_data  = 8'h66;
        @(negedge clk);
        checkOutput("bpInReadyLow", 64'(bus.in_ready), 64'h0);
        checkOutput("bpHoldData", 64'(getData(2)), 64'h55);
        checkOutput("bpHoldValid", 64'(bus.out_valid), 64'h4);
        @(posedge clk);
        #1;
        checkOutput("bpStillHeld", 64'(getData(2)), 64'h55);
        bus.out_ready = 4'b1111;
        @(negedge clk);
        checkOutput("bpInReadyHigh", 64'(bus.in_ready), 64'h1);
        expQ[2].push_back(8'h66);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("bpReloadData", 64'(getData(2)), 64'h66);
        checkOutput("bpReloadValid", 64'(bus.out_valid), 64'h4);
        checkOutput("bpCnt2a", 64'(getCnt(2)), 64'h2);
        @(posedge clk);
        #1;
        checkOutput("bpCnt2b", 64'(getCnt(2)), 64'h3);
        checkOutput("bpKeepData", 64'(getData(2)), 64'h66);

        // Independence: ch1 stalled and full, ch0 and ch3 still flow.
        bus.out_ready = 4'b1101;
        applyStimulus(CH1, 8'h11, 1);
        applyStimulus(CH0, 8'h22, 0);
        applyStimulus(CH3, 8'h33, 3);
        @(posedge clk);
        #1;
        checkOutput("indValid", 64'(bus.out_valid), 64'h2);
        checkOutput("indData1", 64'(getData(1)), 64'h11);
        checkOutput("indCnt", 64'(bus.dlv_cnt), 64'h02_03_01_02);
        bus.out_ready = 4'b1111;
        @(posedge clk);
        #1;
        checkOutput("indRelease", 64'(getCnt(1)), 64'h2);

        // Reset mid-operation with a word stuck in ch2.
        bus.out_ready = 4'b0000;
        applyStimulus(CH2, 8'h77, 2);
        applyReset(2);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("midRstIdle", 64'(bus.out_valid), 64'h0);

        // Counter wrap on ch0.
        bus.out_ready = 4'b1111;
        for (int k = 0; k < 256; k++) begin
            applyStimulus(CH0, 8'(k), 0);
        end
        checkOutput("wrapCnt255", 64'(getCnt(0)), 64'hFF);
        @(posedge clk);
        #1;
        checkOutput("wrapCnt0", 64'(getCnt(0)), 64'h0);
`endif

        // Drain: every expected word must have been delivered.
        bus.out_ready = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drainCh%0d", i), 64'(expQ[i].size()), 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
